// File: rtl/pc_seq_r32i_if.sv
// Control bundle between the instruction decoder/datapath and the PC sequencer.
interface pc_seq_r32i_if #(
  parameter int unsigned dataW = 32
);

  // Decoder / memory side towards the sequencer
  logic             MemReady;
  logic             Stall;
  logic             Halt;
  logic             IsBranch;
  logic             IsJump;
  logic             RegWriteReq;
  logic [2:0]       PCBranchType;
  logic             EQ;
  logic             NE;
  logic             LT;
  logic             LTU;
  logic             GE;
  logic             GEU;

  // Sequencer strobes and status
  logic             MemReq;
  logic             IRLoad;
  logic             PCAdvance;
  logic             BranchControl;
  logic             RegWrite;
  logic             BranchFault;
  logic             Halted;
  logic [dataW-1:0] Retired;

  modport master (
    output MemReady, Stall, Halt, IsBranch, IsJump, RegWriteReq, PCBranchType,
    output EQ, NE, LT, LTU, GE, GEU,
    input  MemReq, IRLoad, PCAdvance, BranchControl, RegWrite, BranchFault,
    input  Halted, Retired
  );

  modport slave (
    input  MemReady, Stall, Halt, IsBranch, IsJump, RegWriteReq, PCBranchType,
    input  EQ, NE, LT, LTU, GE, GEU,
    output MemReq, IRLoad, PCAdvance, BranchControl, RegWrite, BranchFault,
    output Halted, Retired
  );

endinterface

// File: rtl/pc_seq_r32i.sv
// Multi-cycle RV32I instruction sequencer: FETCH -> DECODE -> EXECUTE with
// stall, branch-condition selection, halt and a retired-instruction counter.
module pc_seq_r32i #(
  parameter int unsigned dataW = 32
) (
  input  logic           clock,
  input  logic           reset,
  pc_seq_r32i_if.slave   bus
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    HALTED  = 2'd3
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [dataW-1:0] retired_q;
  logic [dataW-1:0] retired_d;

  logic flag_sel;
  logic type_valid;
  logic advance;

  // Branch condition picked by funct3; 010/011 are not branch encodings
  always_comb begin
    flag_sel   = 1'b0;
    type_valid = 1'b1;
    case (bus.PCBranchType)
      3'b000:  flag_sel = bus.EQ;
      3'b001:  flag_sel = bus.NE;
      3'b100:  flag_sel = bus.LT;
      3'b101:  flag_sel = bus.GE;
      3'b110:  flag_sel = bus.LTU;
      3'b111:  flag_sel = bus.GEU;
      default: type_valid = 1'b0;
    endcase
  end

  // An instruction completes on the first non-stalled EXECUTE cycle
  assign advance = (state_q == EXECUTE) && !bus.Stall;

  // Next state and retire count
  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    case (state_q)
      FETCH:   if (bus.MemReady) state_d = DECODE;
      DECODE:  state_d = bus.Halt ? HALTED : EXECUTE;
      EXECUTE: begin
        if (advance) begin
          state_d   = FETCH;
          retired_d = retired_q + dataW'(1);
        end
      end
      HALTED:  state_d = HALTED;
      default: state_d = FETCH;
    endcase
  end

  // State and counter registers; reset abandons any in-flight instruction
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // MemReq is gated by reset so nothing is requested while reset is held
  assign bus.MemReq        = (state_q == FETCH) && reset;
  assign bus.IRLoad        = (state_q == FETCH) && bus.MemReady && reset;
  assign bus.PCAdvance     = advance;
  assign bus.RegWrite      = advance && bus.RegWriteReq;
  assign bus.BranchControl = advance && (bus.IsJump || (bus.IsBranch && flag_sel));
  assign bus.BranchFault   = advance && bus.IsBranch && !bus.IsJump && !type_valid;
  assign bus.Halted        = (state_q == HALTED);
  assign bus.Retired       = retired_q;

endmodule

// File: tb/tb_pc_seq_r32i.sv
// Self-checking bench for pc_seq_r32i: directed scenarios followed by
// randomized instructions checked against an instruction-level model.
module tb_pc_seq_r32i;

  localparam int unsigned DW = 4;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  int   exp_ret;

  pc_seq_r32i_if #(.dataW(DW)) bus ();

  pc_seq_r32i #(.dataW(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Architectural branch outcome computed from the compared operands
  function automatic bit branch_taken(input logic [2:0] ty, input logic [31:0] a,
                                      input logic [31:0] b);
    case (ty)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) <  $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a <  b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic drive_operands(input logic [31:0] a, input logic [31:0] b);
    bus.EQ  = (a == b);
    bus.NE  = (a != b);
    bus.LT  = ($signed(a) < $signed(b));
    bus.GE  = !($signed(a) < $signed(b));
    bus.LTU = (a < b);
    bus.GEU = !(a < b);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_adv"},  32'(bus.PCAdvance),     32'd0);
    check({tag, "_rw"},   32'(bus.RegWrite),      32'd0);
    check({tag, "_bc"},   32'(bus.BranchControl), 32'd0);
    check({tag, "_bf"},   32'(bus.BranchFault),   32'd0);
    check({tag, "_ret"},  32'(bus.Retired),       32'(exp_ret));
  endtask

  // One full instruction: w fetch-wait cycles, s stall cycles
  task automatic run_instr(input int w, input int s, input bit br, input bit jp,
                           input bit rw, input bit h, input logic [2:0] ty,
                           input logic [31:0] a, input logic [31:0] b);
    bit exp_take;
    bit exp_fault;
    for (int i = 0; i < w; i++) begin
      bus.MemReady = 1'b0;
      bus.Stall    = 1'($urandom);
      bus.Halt     = 1'($urandom);
      #4;
      check("fetch_memreq", 32'(bus.MemReq), 32'd1);
      check("fetch_irload", 32'(bus.IRLoad), 32'd0);
      check("fetch_halted", 32'(bus.Halted), 32'd0);
      check_quiet("fetch");
      tick();
    end
    bus.MemReady = 1'b1;
    bus.Stall    = 1'($urandom);
    bus.Halt     = 1'b0;
    #4;
    check("fetch_memreq", 32'(bus.MemReq), 32'd1);
    check("fetch_irload", 32'(bus.IRLoad), 32'd1);
    check_quiet("fetch");
    tick();
    bus.MemReady     = 1'($urandom);
    bus.Stall        = 1'($urandom);
    bus.Halt         = h;
    bus.IsBranch     = br;
    bus.IsJump       = jp;
    bus.RegWriteReq  = rw;
    bus.PCBranchType = ty;
    drive_operands(a, b);
    #4;
    check("dec_memreq", 32'(bus.MemReq), 32'd0);
    check("dec_irload", 32'(bus.IRLoad), 32'd0);
    check("dec_halted", 32'(bus.Halted), 32'd0);
    check_quiet("dec");
    tick();
    bus.Halt = 1'b0;
    if (h) begin
      for (int i = 0; i < 3; i++) begin
        bus.MemReady = 1'($urandom);
        bus.Stall    = 1'($urandom);
        #4;
        check("halt_halted", 32'(bus.Halted), 32'd1);
        check("halt_memreq", 32'(bus.MemReq), 32'd0);
        check("halt_irload", 32'(bus.IRLoad), 32'd0);
        check_quiet("halt");
        tick();
      end
      return;
    end
    exp_take  = jp || (br && branch_taken(ty, a, b));
    exp_fault = br && !jp && (ty == 3'd2 || ty == 3'd3);
    for (int i = 0; i < s; i++) begin
      bus.Stall    = 1'b1;
      bus.MemReady = 1'($urandom);
      #4;
      check("stall_memreq", 32'(bus.MemReq), 32'd0);
      check("stall_irload", 32'(bus.IRLoad), 32'd0);
      check_quiet("stall");
      tick();
    end
    bus.Stall    = 1'b0;
    bus.MemReady = 1'($urandom);
    #4;
    check("ex_adv",   32'(bus.PCAdvance),     32'd1);
    check("ex_rw",    32'(bus.RegWrite),      32'(rw));
    check("ex_bc",    32'(bus.BranchControl), 32'(exp_take));
    check("ex_bf",    32'(bus.BranchFault),   32'(exp_fault));
    check("ex_ret",   32'(bus.Retired),       32'(exp_ret));
    check("ex_memreq", 32'(bus.MemReq),       32'd0);
    tick();
    exp_ret = (exp_ret + 1) % (1 << DW);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #4;
    check("rst_memreq", 32'(bus.MemReq),  32'd0);
    check("rst_halted", 32'(bus.Halted),  32'd0);
    check("rst_irload", 32'(bus.IRLoad),  32'd0);
    exp_ret = 0;
    check_quiet("rst");
    tick();
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    checks = 0;
    errors = 0;
    exp_ret = 0;
    reset = 1'b0;
    bus.MemReady = 1'b0; bus.Stall = 1'b0; bus.Halt = 1'b0;
    bus.IsBranch = 1'b0; bus.IsJump = 1'b0; bus.RegWriteReq = 1'b0;
    bus.PCBranchType = 3'd0;
    drive_operands(32'd0, 32'd0);
    tick();
    apply_reset();

    // Back-to-back plain instructions with memory always ready
    for (int i = 0; i < 3; i++) run_instr(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'd1, 32'd2);
    // Memory not ready for 4 cycles
    run_instr(4, 0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd1, 32'd2);
    // BNE taken, BNE not taken, invalid funct3 010
    run_instr(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'd5, 32'd7);
    run_instr(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 32'd7, 32'd7);
    run_instr(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd2, 32'd7, 32'd7);
    // Jump with invalid funct3 still takes, no fault
    run_instr(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 32'd1, 32'd1);
    // Two-cycle stall in EXECUTE
    run_instr(0, 2, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    // Halt wins over branch; terminal until reset
    run_instr(0, 0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 32'd3, 32'd3);
    apply_reset();
    run_instr(1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd1);

    // Reset asserted mid-period during a non-stalled EXECUTE
    bus.MemReady = 1'b1; bus.Stall = 1'b0;
    tick();
    bus.IsBranch = 1'b0; bus.IsJump = 1'b1; bus.RegWriteReq = 1'b1;
    tick();
    #2;
    check("midrst_pre_adv", 32'(bus.PCAdvance), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_adv", 32'(bus.PCAdvance),     32'd0);
    check("midrst_rw",  32'(bus.RegWrite),      32'd0);
    check("midrst_bc",  32'(bus.BranchControl), 32'd0);
    check("midrst_ret", 32'(bus.Retired),       32'd0);
    tick();
    check("midrst_ret_after_edge", 32'(bus.Retired), 32'd0);
    reset = 1'b1;
    exp_ret = 0;

    // Randomized instruction stream, long enough to wrap the counter
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_instr(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                1'($urandom), ($urandom_range(0, 4) == 0), 1'($urandom), 1'b0,
                3'($urandom), a, b);
    end
    run_instr(0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_seq_r32i.md
PC_SEQ_R32I -- requirements
Module: pc_seq_r32i

Interface
REQ-001 The block SHALL have parameter dataW, default 32, width of the retired-instruction counter.
REQ-002 The block SHALL have port clock, input, 1, single system clock; all state changes on rising edge.
REQ-003 The block SHALL have port reset, input, 1; reset is asynchronous and active-low.
REQ-004 The block SHALL have port MemReady, input, 1, instruction memory has data valid this cycle.
REQ-005 The block SHALL have port Stall, input, 1, execute-stage hold request.
REQ-006 The block SHALL have port Halt, input, 1, decoded ECALL/EBREAK.
REQ-007 The block SHALL have port IsBranch, input, 1, decoded conditional branch.
REQ-008 The block SHALL have port IsJump, input, 1, decoded JAL/JALR.
REQ-009 The block SHALL have port RegWriteReq, input, 1, decoded instruction writes rd.
REQ-010 The block SHALL have port PCBranchType, input, 3, branch funct3 code.
REQ-011 The block SHALL have ports EQ, NE, LT, LTU, GE, GEU, input, 1 each, comparator flags.
REQ-012 The block SHALL have port MemReq, output, 1, instruction fetch request.
REQ-013 The block SHALL have port IRLoad, output, 1, load instruction register.
REQ-014 The block SHALL have port PCAdvance, output, 1, one-cycle PC update strobe to the PC block.
REQ-015 The block SHALL have port BranchControl, output, 1, PC takes branch offset (valid only with PCAdvance).
REQ-016 The block SHALL have port RegWrite, output, 1, register file write strobe.
REQ-017 The block SHALL have port BranchFault, output, 1, one-cycle pulse on invalid PCBranchType.
REQ-018 The block SHALL have port Halted, output, 1, core stopped.
REQ-019 The block SHALL have port Retired, output, dataW, count of retired instructions.

Function
REQ-020 The FSM SHALL have states FETCH, DECODE, EXECUTE, HALTED; no other reachable states.
REQ-021 In FETCH, MemReq SHALL be 1; IRLoad SHALL equal MemReady (combinational); transition to DECODE on the edge where MemReady=1, else remain.
REQ-022 DECODE SHALL last exactly one cycle: Halt=1 -> HALTED, else -> EXECUTE; Halt SHALL override IsBranch/IsJump.
REQ-023 In EXECUTE with Stall=1, state SHALL hold and PCAdvance, RegWrite, BranchFault SHALL be 0.
REQ-024 In EXECUTE with Stall=0: PCAdvance=1, RegWrite=RegWriteReq, Retired increments, next state FETCH; all in that single cycle.
REQ-025 Branch condition SHALL be selected by PCBranchType: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
REQ-026 BranchControl SHALL be IsJump OR (IsBranch AND selected flag), driven only when PCAdvance=1, else 0.
REQ-027 IsBranch=1 with PCBranchType 010 or 011 SHALL give BranchControl=0 and BranchFault=1 for the PCAdvance cycle; instruction still retires.
REQ-028 IsJump=1 SHALL take regardless of PCBranchType and never raise BranchFault.
REQ-029 Minimum instruction latency SHALL be 3 cycles (FETCH with MemReady=1, DECODE, EXECUTE).
REQ-030 Retired SHALL wrap from 2^dataW-1 to 0 without flag.
REQ-031 HALTED SHALL be terminal until reset: Halted=1, all strobes and MemReq 0, Retired frozen; Halt instruction SHALL not be counted.
REQ-032 MemReady outside FETCH SHALL be ignored; Stall outside EXECUTE SHALL be ignored.

Reset
REQ-033 reset=0 SHALL immediately (asynchronously) force state FETCH, Retired=0, and all registered outputs 0.
REQ-034 Reset asserted mid-instruction SHALL abandon it: no PCAdvance, RegWrite or Retired update.
REQ-035 After reset release, MemReq SHALL be 1 from the first clock cycle in FETCH.

Verification
REQ-036 Reset pulse, MemReady=1 constant, no branch -> PCAdvance every 3rd cycle, BranchControl=0, Retired=1,2,3 after 3,6,9 cycles.
REQ-037 MemReady held 0 for 4 cycles in FETCH -> MemReq=1, IRLoad=0, no state change; MemReady=1 -> IRLoad=1 same cycle, DECODE next.
REQ-038 IsBranch=1, PCBranchType=001, NE=1 -> BranchControl=1 with PCAdvance; repeat with NE=0 -> BranchControl=0; PCBranchType=010 -> BranchFault=1, BranchControl=0.
REQ-039 Stall=1 for 2 cycles in EXECUTE -> PCAdvance delayed exactly 2 cycles, Retired unchanged until release.
REQ-040 Halt=1 with IsBranch=1 in DECODE -> HALTED, Halted=1, MemReq=0, Retired unchanged; reset=0 -> FETCH, Retired=0.
REQ-041 reset=0 asserted mid-clock-period during EXECUTE -> outputs 0 before next edge, no retire counted.
